// File: rtl/dsp_flow_ctrl.sv
// Registered branch-resolution unit: conditional/unconditional jumps, CALL/RET through a
// return-address stack, and one zero-overhead hardware loop, emitting a one-cycle jump request.
module dsp_flow_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 4,
  localparam int CNT_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flow_valid,
  input  logic              stall,
  input  logic [2:0]        flow_mode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [ADDR_W-1:0] target_addr,
  input  logic [ADDR_W-1:0] pc,
  input  logic              err_clr,
  output logic              jump_flag,
  output logic [ADDR_W-1:0] jump_addr,
  output logic [CNT_W-1:0]  stack_count,
  output logic              loop_active,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SLOTS = 1 << IDX_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    FLOW_NONE, FLOW_JMP, FLOW_BEZ, FLOW_BNEZ, FLOW_BLTZ, FLOW_CALL, FLOW_RET, FLOW_LOOP
  } flow_e;

  flow_e mode;
  assign mode = flow_e'(flow_mode);

  logic              jump_q, jump_d;
  logic [ADDR_W-1:0] jump_addr_q, jump_addr_d;
  logic [ADDR_W-1:0] stack_q [SLOTS];
  logic [ADDR_W-1:0] stack_d [SLOTS];
  logic [CNT_W-1:0]  sp_q, sp_d;
  logic              loop_active_q, loop_active_d;
  logic [ADDR_W-1:0] loop_start_q, loop_start_d;
  logic [ADDR_W-1:0] loop_end_q, loop_end_d;
  logic [DATA_W-1:0] loop_count_q, loop_count_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              redirect, is_loop;
  logic [IDX_W-1:0]  push_idx, pop_idx;

  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = IDX_W'(sp_q - 1'b1);

  // NOTE: every variable gets its hold value first so no path through this block infers a latch.
  always_comb begin
    jump_d        = jump_q;
    jump_addr_d   = jump_addr_q;
    stack_d       = stack_q;
    sp_d          = sp_q;
    loop_active_d = loop_active_q;
    loop_start_d  = loop_start_q;
    loop_end_d    = loop_end_q;
    loop_count_d  = loop_count_q;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    redirect      = 1'b0;
    is_loop       = 1'b0;

    if (!stall) begin
      jump_d = 1'b0;
      if (err_clr) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      if (flow_valid) begin
        case (mode)
          FLOW_JMP:  redirect = 1'b1;
          FLOW_BEZ:  redirect = (alu_result == '0);
          FLOW_BNEZ: redirect = (alu_result != '0);
          FLOW_BLTZ: redirect = alu_result[DATA_W-1];
          FLOW_CALL: begin
            if (sp_q < FULL) begin
              redirect          = 1'b1;
              stack_d[push_idx] = pc + 1'b1;
              sp_d              = sp_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          FLOW_RET: begin
            if (sp_q != '0) begin
              jump_d      = 1'b1;
              jump_addr_d = stack_q[pop_idx];
              sp_d        = sp_q - 1'b1;
            end else begin
              unf_d = 1'b1;
            end
          end
          FLOW_LOOP: begin
            is_loop      = 1'b1;
            loop_start_d = pc + 1'b1;
            loop_end_d   = target_addr;
            if (alu_result == '0) begin
              jump_d        = 1'b1;
              jump_addr_d   = target_addr + 1'b1;
              loop_active_d = 1'b0;
              loop_count_d  = '0;
            end else begin
              loop_active_d = 1'b1;
              loop_count_d  = alu_result;
            end
          end
          default: ;
        endcase

        // A taken jump/CALL/RET at loop end wins and leaves the loop counter untouched.
        if (redirect) begin
          jump_d      = 1'b1;
          jump_addr_d = target_addr;
        end else if (mode != FLOW_RET || sp_q == '0) begin
          if (!is_loop && loop_active_q && pc == loop_end_q) begin
            if (loop_count_q > DATA_W'(1)) begin
              jump_d       = 1'b1;
              jump_addr_d  = loop_start_q;
              loop_count_d = loop_count_q - 1'b1;
            end else begin
              loop_active_d = 1'b0;
              loop_count_d  = '0;
            end
          end
        end
      end
    end
  end

  // NOTE: the stack contents are reset too, so a reset leaves no stale return addresses behind.
  always_ff @(posedge clk) begin
    if (!rst) begin
      jump_q        <= 1'b0;
      jump_addr_q   <= '0;
      for (int i = 0; i < SLOTS; i++) stack_q[i] <= '0;
      sp_q          <= '0;
      loop_active_q <= 1'b0;
      loop_start_q  <= '0;
      loop_end_q    <= '0;
      loop_count_q  <= '0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      jump_q        <= jump_d;
      jump_addr_q   <= jump_addr_d;
      stack_q       <= stack_d;
      sp_q          <= sp_d;
      loop_active_q <= loop_active_d;
      loop_start_q  <= loop_start_d;
      loop_end_q    <= loop_end_d;
      loop_count_q  <= loop_count_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
    end
  end

  assign jump_flag     = jump_q;
  assign jump_addr     = jump_addr_q;
  assign stack_count   = sp_q;
  assign loop_active   = loop_active_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_dsp_flow_ctrl.sv
// Bench for dsp_flow_ctrl: queue-based behavioural model compared every cycle, plus
// directed vectors with hand-computed literal expectations.
module tb_dsp_flow_ctrl;

  localparam int DEPTH = 4;
  localparam logic [2:0] M_NONE = 3'd0, M_JMP = 3'd1, M_BEZ = 3'd2, M_BNEZ = 3'd3,
                         M_BLTZ = 3'd4, M_CALL = 3'd5, M_RET = 3'd6, M_LOOP = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flow_valid = 1'b0;
  logic        stall = 1'b0;
  logic        err_clr = 1'b0;
  logic [2:0]  flow_mode = 3'd0;
  logic [15:0] alu_result = 16'd0;
  logic [15:0] target_addr = 16'd0;
  logic [15:0] pc = 16'd0;
  logic        jump_flag;
  logic [15:0] jump_addr;
  logic [2:0]  stack_count;
  logic        loop_active;
  logic        err_overflow;
  logic        err_underflow;

  dsp_flow_ctrl #(.DATA_W(16), .ADDR_W(16), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flow_valid(flow_valid), .stall(stall), .flow_mode(flow_mode),
    .alu_result(alu_result), .target_addr(target_addr), .pc(pc), .err_clr(err_clr),
    .jump_flag(jump_flag), .jump_addr(jump_addr), .stack_count(stack_count),
    .loop_active(loop_active), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: return stack as a LIFO queue, loop as plain integers.
  logic        m_jump = 1'b0;
  logic [15:0] m_addr = 16'd0;
  logic [15:0] m_stack[$];
  logic        m_active = 1'b0;
  logic [15:0] m_start = 16'd0;
  logic [15:0] m_end = 16'd0;
  int unsigned m_cnt = 0;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  always @(posedge clk) begin
    logic taken;
    if (!rst) begin
      m_jump = 1'b0; m_addr = 16'd0; m_stack.delete(); m_active = 1'b0;
      m_start = 16'd0; m_end = 16'd0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
    end else if (!stall) begin
      m_jump = 1'b0;
      if (err_clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (flow_valid) begin
        taken = 1'b0;
        if (flow_mode == M_JMP) taken = 1'b1;
        if (flow_mode == M_BEZ && alu_result == 16'd0) taken = 1'b1;
        if (flow_mode == M_BNEZ && alu_result != 16'd0) taken = 1'b1;
        if (flow_mode == M_BLTZ && alu_result[15]) taken = 1'b1;
        if (flow_mode == M_CALL) begin
          if (m_stack.size() < DEPTH) begin
            m_stack.push_back(pc + 16'd1);
            taken = 1'b1;
          end else m_ovf = 1'b1;
        end
        if (taken) begin
          m_jump = 1'b1; m_addr = target_addr;
        end
        if (flow_mode == M_RET) begin
          if (m_stack.size() > 0) begin
            m_jump = 1'b1; m_addr = m_stack.pop_back(); taken = 1'b1;
          end else m_unf = 1'b1;
        end
        if (flow_mode == M_LOOP) begin
          m_start = pc + 16'd1;
          m_end = target_addr;
          m_cnt = alu_result;
          m_active = (alu_result != 16'd0);
          if (alu_result == 16'd0) begin
            m_jump = 1'b1; m_addr = target_addr + 16'd1;
          end
        end else if (!taken && m_active && pc == m_end) begin
          if (m_cnt > 1) begin
            m_cnt--; m_jump = 1'b1; m_addr = m_start;
          end else begin
            m_cnt = 0; m_active = 1'b0;
          end
        end
      end
    end
    #1;
    check("cyc_jump_flag", 32'(jump_flag), 32'(m_jump));
    if (m_jump) check("cyc_jump_addr", 32'(jump_addr), 32'(m_addr));
    check("cyc_stack_count", 32'(stack_count), m_stack.size());
    check("cyc_loop_active", 32'(loop_active), 32'(m_active));
    check("cyc_err_overflow", 32'(err_overflow), 32'(m_ovf));
    check("cyc_err_underflow", 32'(err_underflow), 32'(m_unf));
  end

  task automatic cyc(input logic v, input logic [2:0] m, input logic [15:0] a, input logic [15:0] t,
                     input logic [15:0] p, input logic s = 1'b0, input logic c = 1'b0,
                     input logic r = 1'b1);
    @(negedge clk);
    rst = r; flow_valid = v; flow_mode = m; alu_result = a; target_addr = t; pc = p;
    stall = s; err_clr = c;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset
    cyc(1'b0, M_NONE, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, M_JMP, 16'd0, 16'h0033, 16'd0, 1'b0, 1'b0, 1'b0);
    check("rst_jump_flag", 32'(jump_flag), 0);
    check("rst_jump_addr", 32'(jump_addr), 0);
    check("rst_stack_count", 32'(stack_count), 0);

    // Conditional branches
    cyc(1'b1, M_BEZ, 16'd0, 16'h0040, 16'd100);
    check("bez0_flag", 32'(jump_flag), 1);
    check("bez0_addr", 32'(jump_addr), 'h40);
    cyc(1'b1, M_BEZ, 16'd5, 16'h0040, 16'd101);
    check("bez5_flag", 32'(jump_flag), 0);
    cyc(1'b1, M_BLTZ, 16'h8000, 16'h0050, 16'd102);
    check("bltz_neg_flag", 32'(jump_flag), 1);
    check("bltz_neg_addr", 32'(jump_addr), 'h50);
    cyc(1'b1, M_BLTZ, 16'h7FFF, 16'h0050, 16'd103);
    check("bltz_pos_flag", 32'(jump_flag), 0);
    cyc(1'b1, M_BNEZ, 16'd1, 16'h0060, 16'd104);
    check("bnez_flag", 32'(jump_flag), 1);
    check("bnez_addr", 32'(jump_addr), 'h60);

    // CALL until overflow, RET until underflow
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, M_CALL, 16'd0, 16'h0100, 16'(i * 10));
      if (i <= 4) check("call_flag", 32'(jump_flag), 1);
    end
    check("call5_flag", 32'(jump_flag), 0);
    check("call5_ovf", 32'(err_overflow), 1);
    check("call5_count", 32'(stack_count), 4);
    for (int i = 4; i >= 0; i--) begin
      cyc(1'b1, M_RET, 16'd0, 16'd0, 16'd200);
      if (i >= 1) check("ret_addr", 32'(jump_addr), i * 10 + 1);
    end
    check("ret5_flag", 32'(jump_flag), 0);
    check("ret5_unf", 32'(err_underflow), 1);
    cyc(1'b1, M_RET, 16'd0, 16'd0, 16'd201, 1'b0, 1'b1);
    check("clr_vs_new_unf", 32'(err_underflow), 1);
    check("clr_ovf", 32'(err_overflow), 0);
    cyc(1'b0, M_NONE, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1);
    check("clr_unf", 32'(err_underflow), 0);

    // Address wrap on CALL
    cyc(1'b1, M_CALL, 16'd0, 16'h0010, 16'hFFFF);
    cyc(1'b1, M_RET, 16'd0, 16'd0, 16'h0010);
    check("wrap_ret_flag", 32'(jump_flag), 1);
    check("wrap_ret_addr", 32'(jump_addr), 0);

    // Hardware loop, N=3
    cyc(1'b1, M_LOOP, 16'd3, 16'd12, 16'd8);
    check("loop_arm_flag", 32'(jump_flag), 0);
    check("loop_arm_active", 32'(loop_active), 1);
    for (int pass = 1; pass <= 3; pass++) begin
      for (int p = 9; p <= 12; p++) cyc(1'b1, M_NONE, 16'd0, 16'd0, 16'(p));
      check("loop_end_flag", 32'(jump_flag), (pass < 3) ? 1 : 0);
      if (pass < 3) check("loop_end_addr", 32'(jump_addr), 9);
    end
    check("loop_done_active", 32'(loop_active), 0);
    cyc(1'b1, M_LOOP, 16'd0, 16'd12, 16'd8);
    check("loop0_flag", 32'(jump_flag), 1);
    check("loop0_addr", 32'(jump_addr), 13);
    check("loop0_active", 32'(loop_active), 0);

    // Stall holds the registered jump and all state
    cyc(1'b1, M_JMP, 16'd0, 16'h0077, 16'h0030);
    cyc(1'b1, M_CALL, 16'd0, 16'h0099, 16'd5, 1'b1);
    check("stall_flag", 32'(jump_flag), 1);
    check("stall_addr", 32'(jump_addr), 'h77);
    check("stall_count", 32'(stack_count), 0);
    cyc(1'b1, M_CALL, 16'd0, 16'h0099, 16'd5, 1'b1);
    check("stall2_addr", 32'(jump_addr), 'h77);
    cyc(1'b0, M_NONE, 16'd0, 16'd0, 16'd0);
    check("unstall_flag", 32'(jump_flag), 0);

    // Taken JMP at loop end leaves the counter unchanged
    cyc(1'b1, M_LOOP, 16'd3, 16'd12, 16'd8);
    cyc(1'b1, M_JMP, 16'd0, 16'h0200, 16'd12);
    check("jmp_at_end_addr", 32'(jump_addr), 'h200);
    check("jmp_at_end_active", 32'(loop_active), 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, M_NONE, 16'd0, 16'd0, 16'd12);
      check("post_jmp_loop_flag", 32'(jump_flag), (k < 2) ? 1 : 0);
    end

    // Reset mid-loop with two stacked returns and a sticky error
    cyc(1'b1, M_RET, 16'd0, 16'd0, 16'd0);
    cyc(1'b1, M_CALL, 16'd0, 16'h0300, 16'd1);
    cyc(1'b1, M_CALL, 16'd0, 16'h0300, 16'd2);
    cyc(1'b1, M_LOOP, 16'd5, 16'd12, 16'd8);
    check("pre_rst_count", 32'(stack_count), 2);
    check("pre_rst_active", 32'(loop_active), 1);
    cyc(1'b1, M_JMP, 16'd0, 16'h0055, 16'd3, 1'b0, 1'b0, 1'b0);
    check("mid_rst_flag", 32'(jump_flag), 0);
    check("mid_rst_addr", 32'(jump_addr), 0);
    check("mid_rst_count", 32'(stack_count), 0);
    check("mid_rst_active", 32'(loop_active), 0);
    check("mid_rst_unf", 32'(err_underflow), 0);
    cyc(1'b1, M_NONE, 16'd0, 16'd0, 16'd12);
    check("post_rst_no_loop", 32'(jump_flag), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
